// File: rtl/bsg_manycore_eva_xlate_arbiter.sv
// ---------------------------------------------------------------------------
// bsg_manycore_eva_xlate_arbiter
//
// Purpose:
//   Shares one EVA->NPA translation datapath among num_req_p requesters.
//   A round-robin arbiter picks one valid EVA per cycle. The EVA is translated
//   combinationally and the result is captured in a one-entry output register
//   drained with a valid/yumi handshake. The block also holds the tile-group
//   origin (TGO) register and a saturating count of invalid-address results.
//
// EVA decode (byte address, data_width_p = 32):
//   eva[31]    == 1    DRAM. word = eva[30:2]; block-striped across the
//                      vcaches: bank = word[lg_blk +: lg_tiles_x] gives the x
//                      subcoord, the next bit picks south (1) or north (0)
//                      vcache row, the remaining upper bits with the block
//                      offset form the EPA.
//                      north: y = {pod_y-1, num_tiles_y-num_vcache_rows}
//                      south: y = {pod_y+1, 0}
//   eva[31:30] == 01   global within own pod: y_sub = eva[24:22],
//                      x_sub = eva[21:18], epa = eva[17:2].
//   eva[31:29] == 001  tile group: same fields, offsets added to the TGO
//                      modulo 2^subcord_width.
//   otherwise          invalid: err=1, x/y/epa = 0.
//
// Ports:
//   clk_i, reset_i        clock, synchronous active-high reset
//   v_i, eva_i, ready_o   requester side; ready_o is a one-hot accept
//   tgo_v_i/x_i/y_i       TGO register write
//   pod_x_i, pod_y_i      own pod coordinates (static)
//   v_o, id_o, x_cord_o, y_cord_o, epa_o, err_o, yumi_i   result handshake
//   err_cnt_o             saturating count of accepted invalid results
// ---------------------------------------------------------------------------
module bsg_manycore_eva_xlate_arbiter
  #(parameter int num_req_p                    = 4
   ,parameter int data_width_p                 = 32
   ,parameter int addr_width_p                 = 28
   ,parameter int x_cord_width_p               = 7
   ,parameter int y_cord_width_p               = 7
   ,parameter int pod_x_cord_width_p           = 3
   ,parameter int pod_y_cord_width_p           = 4
   ,parameter int num_tiles_x_p                = 16
   ,parameter int num_tiles_y_p                = 8
   ,parameter int num_vcache_rows_p            = 1
   ,parameter int vcache_block_size_in_words_p = 8
   ,parameter int vcache_size_p                = 4096
   ,parameter int vcache_sets_p                = 64
   ,parameter int err_cnt_width_p              = 8
   ,localparam int x_subcord_width_lp = x_cord_width_p - pod_x_cord_width_p
   ,localparam int y_subcord_width_lp = y_cord_width_p - pod_y_cord_width_p
   ,localparam int id_width_lp        = $clog2(num_req_p)
   )
   (input  logic                              clk_i
   ,input  logic                              reset_i

   ,input  logic [num_req_p-1:0]              v_i
   ,input  logic [num_req_p*data_width_p-1:0] eva_i
   ,output logic [num_req_p-1:0]              ready_o

   ,input  logic                              tgo_v_i
   ,input  logic [x_subcord_width_lp-1:0]     tgo_x_i
   ,input  logic [y_subcord_width_lp-1:0]     tgo_y_i
   ,input  logic [pod_x_cord_width_p-1:0]     pod_x_i
   ,input  logic [pod_y_cord_width_p-1:0]     pod_y_i

   ,output logic                              v_o
   ,output logic [id_width_lp-1:0]            id_o
   ,output logic [x_cord_width_p-1:0]         x_cord_o
   ,output logic [y_cord_width_p-1:0]         y_cord_o
   ,output logic [addr_width_p-1:0]           epa_o
   ,output logic                              err_o
   ,input  logic                              yumi_i
   ,output logic [err_cnt_width_p-1:0]        err_cnt_o
   );

    localparam int lg_block_lp       = $clog2(vcache_block_size_in_words_p);
    localparam int lg_tiles_x_lp     = $clog2(num_tiles_x_p);
    localparam int epa_tile_width_lp = 16;
    localparam int tile_x_lsb_lp     = 2 + epa_tile_width_lp;
    localparam int tile_y_lsb_lp     = tile_x_lsb_lp + x_subcord_width_lp;
    localparam int dram_hi_shift_lp  = lg_block_lp + lg_tiles_x_lp + 1;

    // Cache geometry must divide evenly into sets of blocks.
    if (vcache_size_p % (vcache_sets_p * vcache_block_size_in_words_p) != 0) begin : g_bad_vcache
        $error("vcache_size_p is not a multiple of vcache_sets_p*vcache_block_size_in_words_p");
    end

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [id_width_lp-1:0]        last_grant;
    logic [x_subcord_width_lp-1:0] tgo_x;
    logic [y_subcord_width_lp-1:0] tgo_y;

    // -----------------------------------------------------------------------
    // Round-robin arbiter: scan last_grant+1 .. last_grant+num_req_p (mod)
    // -----------------------------------------------------------------------
    logic                   can_accept;
    logic                   accept;
    logic                   grant_found;
    logic [id_width_lp-1:0] grant_id;
    logic [id_width_lp:0]   cand;

    assign can_accept = ~v_o | yumi_i;
    assign accept     = can_accept & (|v_i);

    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        cand        = '0;
        for (int i = 1; i <= num_req_p; i++) begin
            cand = {1'b0, last_grant} + (id_width_lp+1)'(i);
            if (cand >= (id_width_lp+1)'(num_req_p))
                cand = cand - (id_width_lp+1)'(num_req_p);
            if (!grant_found && v_i[cand[id_width_lp-1:0]]) begin
                grant_found = 1'b1;
                grant_id    = cand[id_width_lp-1:0];
            end
        end
    end

    always_comb begin
        ready_o = '0;
        if (accept)
            ready_o[grant_id] = 1'b1;
    end

    logic [data_width_p-1:0] sel_eva;

    always_comb begin
        sel_eva = '0;
        for (int r = 0; r < num_req_p; r++) begin
            if (grant_id == id_width_lp'(r))
                sel_eva = eva_i[r*data_width_p +: data_width_p];
        end
    end

    // -----------------------------------------------------------------------
    // Translation of the selected EVA
    // -----------------------------------------------------------------------
    logic is_dram, is_global, is_tile_group;

    assign is_dram       = sel_eva[data_width_p-1];
    assign is_global     = (sel_eva[data_width_p-1 -: 2] == 2'b01);
    assign is_tile_group = (sel_eva[data_width_p-1 -: 3] == 3'b001);

    // DRAM striping
    logic [data_width_p-1:0]       dram_word;
    logic [lg_tiles_x_lp-1:0]      dram_bank;
    logic                          dram_south;
    logic [data_width_p-1:0]       dram_hi;
    logic [data_width_p-1:0]       dram_epa_w;
    logic [x_subcord_width_lp-1:0] dram_x_sub;
    logic [y_subcord_width_lp-1:0] dram_north_y_sub;

    assign dram_word  = {3'b000, sel_eva[data_width_p-2:2]};
    assign dram_bank  = dram_word[lg_block_lp +: lg_tiles_x_lp];
    assign dram_south = dram_word[lg_block_lp + lg_tiles_x_lp];
    assign dram_hi    = dram_word >> dram_hi_shift_lp;
    assign dram_epa_w = (dram_hi << lg_block_lp)
                      | (dram_word & data_width_p'(vcache_block_size_in_words_p - 1));
    assign dram_x_sub       = x_subcord_width_lp'(dram_bank);
    assign dram_north_y_sub = y_subcord_width_lp'(num_tiles_y_p - num_vcache_rows_p);

    // Global / tile-group fields
    logic [x_subcord_width_lp-1:0] off_x;
    logic [y_subcord_width_lp-1:0] off_y;
    logic [epa_tile_width_lp-1:0]  epa_tile;
    logic [x_subcord_width_lp-1:0] tg_x_sub;
    logic [y_subcord_width_lp-1:0] tg_y_sub;

    assign off_x    = sel_eva[tile_x_lsb_lp +: x_subcord_width_lp];
    assign off_y    = sel_eva[tile_y_lsb_lp +: y_subcord_width_lp];
    assign epa_tile = sel_eva[2 +: epa_tile_width_lp];
    // Natural-width add: wraps modulo 2^subcord_width.
    assign tg_x_sub = tgo_x + off_x;
    assign tg_y_sub = tgo_y + off_y;

    logic [x_cord_width_p-1:0] xl_x;
    logic [y_cord_width_p-1:0] xl_y;
    logic [addr_width_p-1:0]   xl_epa;
    logic                      xl_err;

    always_comb begin
        xl_x   = '0;
        xl_y   = '0;
        xl_epa = '0;
        xl_err = 1'b0;
        if (is_dram) begin
            xl_x   = {pod_x_i, dram_x_sub};
            xl_y   = dram_south
                   ? {pod_y_i + pod_y_cord_width_p'(1), y_subcord_width_lp'(0)}
                   : {pod_y_i - pod_y_cord_width_p'(1), dram_north_y_sub};
            xl_epa = dram_epa_w[addr_width_p-1:0];
        end
        else if (is_global) begin
            xl_x   = {pod_x_i, off_x};
            xl_y   = {pod_y_i, off_y};
            xl_epa = {{(addr_width_p-epa_tile_width_lp){1'b0}}, epa_tile};
        end
        else if (is_tile_group) begin
            xl_x   = {pod_x_i, tg_x_sub};
            xl_y   = {pod_y_i, tg_y_sub};
            xl_epa = {{(addr_width_p-epa_tile_width_lp){1'b0}}, epa_tile};
        end
        else begin
            xl_err = 1'b1;
        end
    end

    // Byte offset and bits above the EPA range are don't-care.
    logic unused_bits;
    assign unused_bits = ^{sel_eva[1:0], dram_epa_w[data_width_p-1:addr_width_p]};

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            v_o        <= 1'b0;
            id_o       <= '0;
            x_cord_o   <= '0;
            y_cord_o   <= '0;
            epa_o      <= '0;
            err_o      <= 1'b0;
            err_cnt_o  <= '0;
            last_grant <= id_width_lp'(num_req_p - 1);
            tgo_x      <= '0;
            tgo_y      <= '0;
        end
        else begin
            if (accept) begin
                v_o        <= 1'b1;
                id_o       <= grant_id;
                x_cord_o   <= xl_x;
                y_cord_o   <= xl_y;
                epa_o      <= xl_epa;
                err_o      <= xl_err;
                last_grant <= grant_id;
                if (xl_err && (err_cnt_o != '1))
                    err_cnt_o <= err_cnt_o + err_cnt_width_p'(1);
            end
            else if (yumi_i) begin
                v_o <= 1'b0;
            end

            // Translation above already used the old TGO this cycle.
            if (tgo_v_i) begin
                tgo_x <= tgo_x_i;
                tgo_y <= tgo_y_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i)
            assert (!(yumi_i && !v_o));
    end

endmodule

// File: tb/tb_bsg_manycore_eva_xlate_arbiter.sv
module tb_bsg_manycore_eva_xlate_arbiter;

    localparam int N     = 4;
    localparam int XS_N  = 16;   // 2^x_subcord
    localparam int YS_N  = 8;    // 2^y_subcord
    localparam int PY_N  = 16;   // 2^pod_y width
    localparam int BLK   = 8;
    localparam int NTX   = 16;
    localparam int NTY   = 8;
    localparam int NVR   = 1;
    localparam int CMAX  = 255;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    v;
    logic [31:0]     eva_arr [N];
    logic [N*32-1:0] eva_bus;
    logic [N-1:0]    ready_o;
    logic            tgo_v;
    logic [3:0]      tgo_x;
    logic [2:0]      tgo_y;
    logic [2:0]      pod_x;
    logic [3:0]      pod_y;
    logic            v_o;
    logic [1:0]      id_o;
    logic [6:0]      x_cord_o;
    logic [6:0]      y_cord_o;
    logic [27:0]     epa_o;
    logic            err_o;
    logic            yumi;
    logic [7:0]      err_cnt_o;

    for (genvar r = 0; r < N; r++) begin : g_pack
        assign eva_bus[r*32 +: 32] = eva_arr[r];
    end

    always #5 clk = ~clk;

    bsg_manycore_eva_xlate_arbiter dut
        (.clk_i(clk), .reset_i(reset)
        ,.v_i(v), .eva_i(eva_bus), .ready_o(ready_o)
        ,.tgo_v_i(tgo_v), .tgo_x_i(tgo_x), .tgo_y_i(tgo_y)
        ,.pod_x_i(pod_x), .pod_y_i(pod_y)
        ,.v_o(v_o), .id_o(id_o), .x_cord_o(x_cord_o), .y_cord_o(y_cord_o)
        ,.epa_o(epa_o), .err_o(err_o), .yumi_i(yumi), .err_cnt_o(err_cnt_o));

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    int     m_last;
    bit     m_v;
    int     m_id;
    longint m_x, m_y, m_epa;
    bit     m_err;
    int     m_cnt;
    int     m_tgx, m_tgy;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic void xlate(input logic [31:0] eva, input int tgx, input int tgy,
                                  output longint x, output longint y, output longint epa,
                                  output bit err);
        longint e, w, off, xo, yo;
        longint px, py;
        e = longint'(eva);
        px = longint'(pod_x);
        py = longint'(pod_y);
        x = 0; y = 0; epa = 0; err = 0;
        if (e >= (longint'(1) << 31)) begin
            w = (e - (longint'(1) << 31)) / 4;
            x = px * XS_N + (w / BLK) % NTX;
            if (((w / (BLK * NTX)) % 2) == 1)
                y = ((py + 1) % PY_N) * YS_N;
            else
                y = ((py + PY_N - 1) % PY_N) * YS_N + (NTY - NVR);
            epa = (w / (BLK * NTX * 2)) * BLK + (w % BLK);
        end
        else if (e / (longint'(1) << 29) >= 1) begin
            off = e % (longint'(1) << 29);
            xo  = (off / (longint'(1) << 18)) % XS_N;
            yo  = (off / (longint'(1) << 22)) % YS_N;
            epa = (off / 4) % 65536;
            if (e / (longint'(1) << 30) == 1) begin
                x = px * XS_N + xo;
                y = py * YS_N + yo;
            end
            else begin
                x = px * XS_N + (tgx + xo) % XS_N;
                y = py * YS_N + (tgy + yo) % YS_N;
            end
        end
        else begin
            err = 1;
        end
    endfunction

    function automatic int m_grant();
        if (reset) return -1;
        if (m_v && !yumi) return -1;
        for (int k = 1; k <= N; k++) begin
            int r;
            r = (m_last + k) % N;
            if (v[r]) return r;
        end
        return -1;
    endfunction

    task automatic m_reset();
        m_v = 0; m_id = 0; m_x = 0; m_y = 0; m_epa = 0; m_err = 0;
        m_cnt = 0; m_last = N - 1; m_tgx = 0; m_tgy = 0;
    endtask

    task automatic m_update(input int g);
        if (reset) begin
            m_reset();
        end
        else begin
            if (g >= 0) begin
                xlate(eva_arr[g], m_tgx, m_tgy, m_x, m_y, m_epa, m_err);
                m_v = 1; m_id = g; m_last = g;
                if (m_err && m_cnt < CMAX) m_cnt++;
            end
            else if (yumi) begin
                m_v = 0;
            end
            if (tgo_v) begin
                m_tgx = int'(tgo_x);
                m_tgy = int'(tgo_y);
            end
        end
    endtask

    // One clock: check combinational grant and registered outputs at the
    // falling edge, then advance the model at the rising edge.
    task automatic cycle(input bit use_exp = 0, input logic [N-1:0] exp_ready = '0);
        int g;
        g = m_grant();
        @(negedge clk);
        if (!reset) begin
            chk("ready", 64'(ready_o), (g >= 0) ? (64'd1 << g) : 64'd0);
            if (use_exp) chk("ready_dir", 64'(ready_o), 64'(exp_ready));
        end
        chk("v_o", 64'(v_o), 64'(m_v));
        chk("id_o", 64'(id_o), 64'(m_id));
        chk("x_cord", 64'(x_cord_o), 64'(m_x));
        chk("y_cord", 64'(y_cord_o), 64'(m_y));
        chk("epa", 64'(epa_o), 64'(m_epa));
        chk("err_o", 64'(err_o), 64'(m_err));
        chk("err_cnt", 64'(err_cnt_o), 64'(m_cnt));
        @(posedge clk);
        m_update(g);
        #1;
    endtask

    function automatic logic [31:0] tg_eva(input int xo, input int yo, input int word);
        return {3'b001, 4'b0000, 3'(yo), 4'(xo), 16'(word), 2'b00};
    endfunction

    function automatic logic [31:0] rand_eva();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 3))
            0: r[31]    = 1'b1;
            1: r[31:30] = 2'b01;
            2: r[31:29] = 3'b001;
            default: r[31:29] = 3'b000;
        endcase
        return r;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1; v = '0; yumi = 0; tgo_v = 0; tgo_x = '0; tgo_y = '0;
        pod_x = 3'd1; pod_y = 4'd1;
        for (int r = 0; r < N; r++) eva_arr[r] = 32'h0;
        m_reset();
        @(posedge clk); #1;
        cycle();
        chk("rst_v_o", 64'(v_o), 64'd0);
        chk("rst_err_cnt", 64'(err_cnt_o), 64'd0);
        chk("rst_epa", 64'(epa_o), 64'd0);
        reset = 0;

        // 1: round robin with all requesting, always draining
        for (int r = 0; r < N; r++) eva_arr[r] = 32'h8000_0000 | (32'(r) << 6);
        v = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            yumi = m_v;
            cycle(1, 4'(1 << (i % 4)));
        end
        v = '0; yumi = m_v; cycle(); yumi = 0;

        // 2: backpressure freezes outputs, yumi releases a same-cycle grant
        reset = 1; cycle(); reset = 0;
        v = 4'b0101;
        eva_arr[0] = 32'h4012_3454; eva_arr[2] = 32'h2034_5678;
        cycle(1, 4'b0001);
        for (int i = 0; i < 5; i++) cycle(1, 4'b0000);
        yumi = 1; cycle(1, 4'b0100);
        chk("t2_id", 64'(id_o), 64'd2);
        v = '0; cycle(); yumi = 0;

        // 3: tile-group translation with pod (1,1) and TGO (2,1)
        tgo_v = 1; tgo_x = 4'd2; tgo_y = 3'd1; cycle(); tgo_v = 0;
        eva_arr[0] = tg_eva(1, 2, 16'h10); v = 4'b0001;
        cycle();
        chk("t3_x", 64'(x_cord_o), 64'h13);
        chk("t3_y", 64'(y_cord_o), 64'h0B);
        chk("t3_epa", 64'(epa_o), 64'h10);
        chk("t3_err", 64'(err_o), 64'd0);

        // 4: same-cycle TGO write uses the old TGO
        yumi = 1; tgo_v = 1; tgo_x = 4'd5; tgo_y = 3'd5;
        eva_arr[0] = tg_eva(1, 1, 16'h20);
        cycle(); tgo_v = 0;
        chk("t4_x_old", 64'(x_cord_o), 64'h13);
        chk("t4_y_old", 64'(y_cord_o), 64'h0A);
        cycle();
        chk("t4_x_new", 64'(x_cord_o), 64'h16);
        chk("t4_y_new", 64'(y_cord_o), 64'h0E);
        v = '0; cycle(); yumi = 0;

        // 5: invalid addresses saturate the error counter
        reset = 1; cycle(); reset = 0;
        eva_arr[0] = 32'h0000_1000; v = 4'b0001;
        for (int i = 0; i < 300; i++) begin
            yumi = m_v;
            cycle();
        end
        chk("t5_err", 64'(err_o), 64'd1);
        chk("t5_x", 64'(x_cord_o), 64'd0);
        chk("t5_epa", 64'(epa_o), 64'd0);
        chk("t5_cnt", 64'(err_cnt_o), 64'd255);
        v = '0; yumi = m_v; cycle(); yumi = 0;

        // 6: reset discards a held result; requester 0 is first afterwards
        v = 4'b0001; cycle();
        v = '0; cycle();
        reset = 1; v = 4'b1111; cycle(); reset = 0;
        chk("t6_v_o", 64'(v_o), 64'd0);
        chk("t6_cnt", 64'(err_cnt_o), 64'd0);
        for (int r = 0; r < N; r++) eva_arr[r] = 32'h4000_0000 | (32'(r) << 18);
        cycle(1, 4'b0001);
        v = '0; yumi = m_v; cycle(); yumi = 0;

        // random traffic against the model
        for (int i = 0; i < 500; i++) begin
            v = 4'($urandom_range(0, 15));
            for (int r = 0; r < N; r++) eva_arr[r] = rand_eva();
            yumi  = m_v ? 1'($urandom_range(0, 1)) : 1'b0;
            tgo_v = ($urandom_range(0, 7) == 0);
            tgo_x = 4'($urandom);
            tgo_y = 3'($urandom);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
